// File: rtl/arm_pipe_ctrl_gen.sv
// Five-stage ARM pipeline controller: extended DP decode, multi-cycle MUL in E, MEM_STAGES-deep M pipe.
// Latency: decode is combinational, E is registered, W is MEM_STAGES+1 cycles after E (stalls excluded).
// Backpressure: MulStallE freezes F/D/E while a MUL occupies E; M1 takes bubbles during the stall.
module arm_pipe_ctrl_gen #(
    parameter int MEM_STAGES = 1,
    parameter int MUL_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrD,
    input  logic [3:0]  ALUFlagsE,
    input  logic        FlushE,
    output logic [1:0]  RegSrcD,
    output logic [1:0]  ImmSrcD,
    output logic        ALUSrcE,
    output logic [3:0]  ALUControlE,
    output logic        MulE,
    output logic        CarryE,
    output logic        BranchTakenE,
    output logic        MulStallE,
    output logic        MemWriteM,
    output logic        RegWriteM,
    output logic        MemtoRegE,
    output logic        MemtoRegW,
    output logic        RegWriteW,
    output logic        PCSrcW,
    output logic        PCWrPendingF,
    output logic [3:0]  FlagsE
);

    localparam bit MULTI_CYCLE = (MUL_CYCLES > 1);
    localparam int CNT_W = MULTI_CYCLE ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULTI_CYCLE ? MUL_CYCLES - 2 : 0);

    typedef struct packed {
        logic       regWrite;
        logic       memWrite;
        logic       memtoReg;
        logic       pcSrc;
        logic       branch;
        logic [1:0] flagWrite;
        logic       aluSrc;
        logic [3:0] aluControl;
        logic       mul;
        logic [3:0] cond;
    } eCtrl_t;

    typedef struct packed {
        logic regWrite;
        logic memWrite;
        logic memtoReg;
        logic pcSrc;
    } memCtrl_t;

    typedef enum logic {IDLE, BUSY} mulState_t;

    eCtrl_t     dCtrl;
    eCtrl_t     eCtrl;
    memCtrl_t   mIn;
    memCtrl_t   mPipe [MEM_STAGES];
    mulState_t  mulState;
    logic [CNT_W-1:0] cnt;

    logic [1:0] op;
    logic [3:0] opcode;
    logic [3:0] rd;
    logic       sBit;
    logic       isMulD;
    logic       isArith;
    logic       condExE;
    logic       mulStart;
    logic [1:0] flagWriteG;
    logic       mPend;
    logic       unusedBits;

    assign op     = InstrD[27:26];
    assign opcode = InstrD[24:21];
    assign sBit   = InstrD[20];
    assign isMulD = (InstrD[27:22] == 6'b000000) && (InstrD[7:4] == 4'b1001);
    assign rd     = isMulD ? InstrD[19:16] : InstrD[15:12];

    always_comb begin
        case (opcode)
            4'b0010, 4'b0011, 4'b0100, 4'b0101,
            4'b0110, 4'b0111, 4'b1010, 4'b1011: isArith = 1'b1;
            default:                            isArith = 1'b0;
        endcase
    end

    always_comb begin
        dCtrl            = '0;
        dCtrl.cond       = InstrD[31:28];
        dCtrl.aluControl = 4'b0100;
        RegSrcD          = 2'b00;
        ImmSrcD          = 2'b00;
        if (isMulD) begin
            dCtrl.regWrite   = 1'b1;
            dCtrl.flagWrite  = {sBit, 1'b0};
            dCtrl.mul        = 1'b1;
            dCtrl.aluControl = opcode;
        end else if (op == 2'b00) begin
            // TST/TEQ/CMP/CMN only set flags
            dCtrl.regWrite   = (opcode[3:2] != 2'b10);
            dCtrl.flagWrite  = {sBit, sBit & isArith};
            dCtrl.aluSrc     = InstrD[25];
            dCtrl.aluControl = opcode;
        end else if (op == 2'b01) begin
            dCtrl.regWrite = InstrD[20];
            dCtrl.memWrite = ~InstrD[20];
            dCtrl.memtoReg = InstrD[20];
            dCtrl.aluSrc   = 1'b1;
            ImmSrcD        = 2'b01;
            RegSrcD[1]     = ~InstrD[20];
        end else if (op == 2'b10) begin
            dCtrl.branch = 1'b1;
            dCtrl.aluSrc = 1'b1;
            ImmSrcD      = 2'b10;
            RegSrcD[0]   = 1'b1;
        end
        dCtrl.pcSrc = dCtrl.regWrite && (rd == 4'hF);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            eCtrl <= '0;
        end else if (!MulStallE) begin
            eCtrl <= FlushE ? '0 : dCtrl;
        end
    end

    always_comb begin
        case (eCtrl.cond)
            4'b0000: condExE = FlagsE[2];
            4'b0001: condExE = ~FlagsE[2];
            4'b0010: condExE = FlagsE[1];
            4'b0011: condExE = ~FlagsE[1];
            4'b0100: condExE = FlagsE[3];
            4'b0101: condExE = ~FlagsE[3];
            4'b0110: condExE = FlagsE[0];
            4'b0111: condExE = ~FlagsE[0];
            4'b1000: condExE = FlagsE[1] & ~FlagsE[2];
            4'b1001: condExE = ~FlagsE[1] | FlagsE[2];
            4'b1010: condExE = (FlagsE[3] == FlagsE[0]);
            4'b1011: condExE = (FlagsE[3] != FlagsE[0]);
            4'b1100: condExE = ~FlagsE[2] & (FlagsE[3] == FlagsE[0]);
            4'b1101: condExE = FlagsE[2] | (FlagsE[3] != FlagsE[0]);
            4'b1110: condExE = 1'b1;
            default: condExE = 1'b0;
        endcase
    end

    assign flagWriteG = eCtrl.flagWrite & {2{condExE}};
    assign mulStart   = MULTI_CYCLE && (mulState == IDLE) && eCtrl.mul && condExE;
    assign MulStallE  = mulStart || ((mulState == BUSY) && (cnt != '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            mulState <= IDLE;
            cnt      <= '0;
        end else begin
            case (mulState)
                IDLE: begin
                    if (mulStart) begin
                        mulState <= BUSY;
                        cnt      <= CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt == '0) mulState <= IDLE;
                    else           cnt      <= cnt - CNT_W'(1);
                end
                default: mulState <= IDLE;
            endcase
        end
    end

    // Flags only commit on the non-stalled (final) E cycle of an instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            FlagsE <= 4'b0000;
        end else if (!MulStallE) begin
            if (flagWriteG[1]) FlagsE[3:2] <= ALUFlagsE[3:2];
            if (flagWriteG[0]) FlagsE[1:0] <= ALUFlagsE[1:0];
        end
    end

    assign mIn.regWrite = eCtrl.regWrite & condExE;
    assign mIn.memWrite = eCtrl.memWrite & condExE;
    assign mIn.memtoReg = eCtrl.memtoReg;
    assign mIn.pcSrc    = eCtrl.pcSrc & condExE;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_STAGES; i++) mPipe[i] <= '0;
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            PCSrcW    <= 1'b0;
        end else begin
            mPipe[0] <= MulStallE ? '0 : mIn;
            for (int i = 1; i < MEM_STAGES; i++) mPipe[i] <= mPipe[i-1];
            RegWriteW <= mPipe[MEM_STAGES-1].regWrite;
            MemtoRegW <= mPipe[MEM_STAGES-1].memtoReg;
            PCSrcW    <= mPipe[MEM_STAGES-1].pcSrc;
        end
    end

    always_comb begin
        mPend = 1'b0;
        for (int i = 0; i < MEM_STAGES; i++) mPend = mPend | mPipe[i].pcSrc;
    end

    assign PCWrPendingF = dCtrl.pcSrc | eCtrl.pcSrc | mPend;
    assign ALUSrcE      = eCtrl.aluSrc;
    assign ALUControlE  = eCtrl.aluControl;
    assign MulE         = eCtrl.mul;
    assign MemtoRegE    = eCtrl.memtoReg;
    assign CarryE       = FlagsE[1];
    assign BranchTakenE = eCtrl.branch & condExE;
    assign MemWriteM    = mPipe[0].memWrite;
    assign RegWriteM    = mPipe[0].regWrite;
    assign unusedBits   = ^{InstrD[11:8], InstrD[3:0], mPipe[MEM_STAGES-1].memWrite};

endmodule

// File: tb/tb_arm_pipe_ctrl_gen.sv
// Scoreboard bench for arm_pipe_ctrl_gen: expectations are queued with a target cycle as stimulus
// is driven, and popped/compared on the falling edge of that cycle.
module tb_arm_pipe_ctrl_gen;

    localparam int MS = 3;
    localparam int MC = 3;

    localparam int SIG_ALUCTL = 0,  SIG_ALUSRC = 1,  SIG_MULE   = 2,  SIG_CARRY  = 3;
    localparam int SIG_BT     = 4,  SIG_STALL  = 5,  SIG_MEMWM  = 6,  SIG_REGWM  = 7;
    localparam int SIG_MTRE   = 8,  SIG_MTRW   = 9,  SIG_REGWW  = 10, SIG_PCSRCW = 11;
    localparam int SIG_PCPEND = 12, SIG_FLAGS  = 13, SIG_REGSRC = 14, SIG_IMMSRC = 15;

    localparam logic [31:0] NOP    = 32'hEC00_0000;
    localparam logic [31:0] ADDS   = 32'hE292_1001;
    localparam logic [31:0] ADDI   = 32'hE281_1001;
    localparam logic [31:0] CMP0   = 32'hE350_0000;
    localparam logic [31:0] BEQ    = 32'h0A00_0000;
    localparam logic [31:0] BNE    = 32'h1A00_0000;
    localparam logic [31:0] MULS   = 32'hE013_0291;
    localparam logic [31:0] MULNE  = 32'h1003_0291;
    localparam logic [31:0] STR    = 32'hE582_1000;
    localparam logic [31:0] LDRPC  = 32'hE59F_F000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstrD;
    logic [3:0]  ALUFlagsE;
    logic        FlushE;
    logic [1:0]  RegSrcD, ImmSrcD;
    logic        ALUSrcE, MulE, CarryE, BranchTakenE, MulStallE;
    logic [3:0]  ALUControlE, FlagsE;
    logic        MemWriteM, RegWriteM, MemtoRegE, MemtoRegW, RegWriteW, PCSrcW, PCWrPendingF;

    typedef struct {
        int         cyc;
        int         sig;
        logic [3:0] val;
        string      tag;
    } expT;

    expT q[$];
    int  cyc = 0;
    int  nChecks = 0;
    int  nErrors = 0;

    arm_pipe_ctrl_gen #(.MEM_STAGES(MS), .MUL_CYCLES(MC)) dut (
        .clk(clk), .reset(reset), .InstrD(InstrD), .ALUFlagsE(ALUFlagsE), .FlushE(FlushE),
        .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .MulE(MulE), .CarryE(CarryE), .BranchTakenE(BranchTakenE), .MulStallE(MulStallE),
        .MemWriteM(MemWriteM), .RegWriteM(RegWriteM), .MemtoRegE(MemtoRegE),
        .MemtoRegW(MemtoRegW), .RegWriteW(RegWriteW), .PCSrcW(PCSrcW),
        .PCWrPendingF(PCWrPendingF), .FlagsE(FlagsE)
    );

    always #5 clk = ~clk;

    task automatic chkEq(input string tag, input logic [3:0] got, input logic [3:0] want);
        nChecks++;
        if (got !== want) begin
            nErrors++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, want);
        end
    endtask

    function automatic logic [3:0] sampleSig(input int sig);
        case (sig)
            SIG_ALUCTL: return ALUControlE;
            SIG_ALUSRC: return {3'b0, ALUSrcE};
            SIG_MULE:   return {3'b0, MulE};
            SIG_CARRY:  return {3'b0, CarryE};
            SIG_BT:     return {3'b0, BranchTakenE};
            SIG_STALL:  return {3'b0, MulStallE};
            SIG_MEMWM:  return {3'b0, MemWriteM};
            SIG_REGWM:  return {3'b0, RegWriteM};
            SIG_MTRE:   return {3'b0, MemtoRegE};
            SIG_MTRW:   return {3'b0, MemtoRegW};
            SIG_REGWW:  return {3'b0, RegWriteW};
            SIG_PCSRCW: return {3'b0, PCSrcW};
            SIG_PCPEND: return {3'b0, PCWrPendingF};
            SIG_FLAGS:  return FlagsE;
            SIG_REGSRC: return {2'b0, RegSrcD};
            SIG_IMMSRC: return {2'b0, ImmSrcD};
            default:    return 4'hx;
        endcase
    endfunction

    task automatic expAt(input int dc, input int sig, input logic [3:0] val, input string tag);
        expT e;
        e.cyc = cyc + dc;
        e.sig = sig;
        e.val = val;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic drive(input logic [31:0] ins, input logic [3:0] af, input logic fl);
        InstrD    = ins;
        ALUFlagsE = af;
        FlushE    = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                chkEq(q[i].tag, sampleSig(q[i].sig), q[i].val);
                q.delete(i);
            end
        end
    end

    initial begin
        reset = 1'b1;
        drive(32'h0, 4'h0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        expAt(0, SIG_FLAGS,  4'h0, "rst_flags");
        expAt(0, SIG_STALL,  4'h0, "rst_stall");
        expAt(0, SIG_MULE,   4'h0, "rst_mule");
        expAt(0, SIG_ALUCTL, 4'h0, "rst_aluctl");
        expAt(0, SIG_ALUSRC, 4'h0, "rst_alusrc");
        expAt(0, SIG_REGWM,  4'h0, "rst_regwm");
        expAt(0, SIG_MEMWM,  4'h0, "rst_memwm");
        expAt(0, SIG_REGWW,  4'h0, "rst_regww");
        expAt(0, SIG_PCSRCW, 4'h0, "rst_pcsrcw");
        expAt(0, SIG_MTRE,   4'h0, "rst_mtre");
        expAt(0, SIG_MTRW,   4'h0, "rst_mtrw");
        expAt(0, SIG_BT,     4'h0, "rst_bt");
        expAt(0, SIG_PCPEND, 4'h0, "rst_pcpend");
        expAt(0, SIG_CARRY,  4'h0, "rst_carry");
        tick();

        // ADDS r1,r2,#1
        drive(ADDS, 4'h0, 1'b0);
        expAt(0,      SIG_IMMSRC, 4'h0, "adds_immsrc");
        expAt(1,      SIG_ALUCTL, 4'h4, "adds_aluctl");
        expAt(1,      SIG_ALUSRC, 4'h1, "adds_alusrc");
        expAt(2,      SIG_FLAGS,  4'h6, "adds_flags");
        expAt(2,      SIG_CARRY,  4'h1, "adds_carry");
        expAt(2,      SIG_REGWM,  4'h1, "adds_regwm");
        expAt(MS + 1, SIG_REGWW,  4'h0, "adds_regww_early");
        expAt(MS + 2, SIG_REGWW,  4'h1, "adds_regww");
        tick();
        drive(NOP, 4'b0110, 1'b0);
        tick();
        drive(NOP, 4'h0, 1'b0);
        tick();

        // CMP r0,#0 ; BEQ ; BNE
        drive(CMP0, 4'h0, 1'b0);
        expAt(1,      SIG_ALUCTL, 4'hA, "cmp_aluctl");
        expAt(2,      SIG_FLAGS,  4'h4, "cmp_flags");
        expAt(2,      SIG_REGWM,  4'h0, "cmp_regwm");
        expAt(2,      SIG_BT,     4'h1, "beq_taken");
        expAt(3,      SIG_BT,     4'h0, "bne_nottaken");
        expAt(MS + 2, SIG_REGWW,  4'h0, "cmp_regww");
        tick();
        drive(BEQ, 4'b0100, 1'b0);
        expAt(0, SIG_REGSRC, 4'h1, "beq_regsrc");
        expAt(0, SIG_IMMSRC, 4'h2, "beq_immsrc");
        tick();
        drive(BNE, 4'h0, 1'b0);
        tick();
        drive(NOP, 4'h0, 1'b0);
        tick();

        // MULS r3,r1,r2: two stall cycles, FlushE during the stall ignored
        drive(MULS, 4'h0, 1'b0);
        expAt(1,      SIG_STALL, 4'h1, "muls_stall1");
        expAt(1,      SIG_MULE,  4'h1, "muls_mule1");
        expAt(2,      SIG_STALL, 4'h1, "muls_stall2");
        expAt(2,      SIG_REGWM, 4'h0, "muls_bubble1");
        expAt(3,      SIG_STALL, 4'h0, "muls_stall3");
        expAt(3,      SIG_MULE,  4'h1, "muls_mule3");
        expAt(3,      SIG_REGWM, 4'h0, "muls_bubble2");
        expAt(3,      SIG_FLAGS, 4'h4, "muls_flags_held");
        expAt(4,      SIG_FLAGS, 4'h8, "muls_flags");
        expAt(4,      SIG_REGWM, 4'h1, "muls_regwm");
        expAt(4,      SIG_STALL, 4'h0, "muls_stall_done");
        expAt(4,      SIG_MULE,  4'h0, "muls_mule_done");
        expAt(3 + MS, SIG_REGWW, 4'h0, "muls_regww_early");
        expAt(4 + MS, SIG_REGWW, 4'h1, "muls_regww");
        tick();
        drive(NOP, 4'b1011, 1'b0);
        tick();
        drive(NOP, 4'b1011, 1'b1);
        tick();
        drive(NOP, 4'b1011, 1'b0);
        tick();
        drive(NOP, 4'h0, 1'b0);
        tick();

        // CMP sets Z, then MULNE fails its condition
        drive(CMP0, 4'h0, 1'b0);
        expAt(2, SIG_FLAGS, 4'h4, "mulne_flags");
        expAt(2, SIG_STALL, 4'h0, "mulne_nostall");
        expAt(2, SIG_MULE,  4'h1, "mulne_mule");
        expAt(3, SIG_MULE,  4'h0, "mulne_onecycle");
        expAt(3, SIG_STALL, 4'h0, "mulne_nostall2");
        expAt(3, SIG_REGWM, 4'h0, "mulne_regwm");
        tick();
        drive(MULNE, 4'b0100, 1'b0);
        tick();
        drive(NOP, 4'h0, 1'b0);
        tick();
        tick();

        // STR r1,[r2]
        drive(STR, 4'h0, 1'b0);
        expAt(0, SIG_REGSRC, 4'h2, "str_regsrc");
        expAt(0, SIG_IMMSRC, 4'h1, "str_immsrc");
        expAt(2, SIG_MEMWM,  4'h1, "str_memwm");
        expAt(2, SIG_REGWM,  4'h0, "str_regwm");
        tick();
        drive(NOP, 4'h0, 1'b0);
        tick();

        // FlushE outside a stall turns the incoming ADD into a bubble
        drive(ADDI, 4'h0, 1'b1);
        expAt(1, SIG_ALUCTL, 4'h0, "flush_aluctl");
        expAt(1, SIG_ALUSRC, 4'h0, "flush_alusrc");
        expAt(2, SIG_REGWM,  4'h0, "flush_regwm");
        tick();
        drive(NOP, 4'h0, 1'b0);
        tick();

        // Reset during the second stall cycle of a MUL
        for (int i = 0; i < 4; i++) begin
            drive(ADDI, 4'h0, 1'b0);
            tick();
        end
        drive(MULS, 4'h0, 1'b0);
        expAt(1, SIG_STALL,  4'h1, "rmul_stall1");
        expAt(2, SIG_STALL,  4'h1, "rmul_stall2");
        expAt(2, SIG_FLAGS,  4'h4, "rmul_flags_pre");
        expAt(2, SIG_REGWW,  4'h1, "rmul_regww_pre");
        expAt(3, SIG_STALL,  4'h0, "rmul_stall_rst");
        expAt(3, SIG_MULE,   4'h0, "rmul_mule_rst");
        expAt(3, SIG_FLAGS,  4'h0, "rmul_flags_rst");
        expAt(3, SIG_REGWM,  4'h0, "rmul_regwm_rst");
        expAt(3, SIG_REGWW,  4'h0, "rmul_regww_rst");
        expAt(3, SIG_ALUCTL, 4'h0, "rmul_aluctl_rst");
        expAt(3, SIG_ALUSRC, 4'h0, "rmul_alusrc_rst");
        expAt(3, SIG_PCPEND, 4'h0, "rmul_pcpend_rst");
        expAt(4, SIG_REGWW,  4'h0, "rmul_regww_rst2");
        tick();
        drive(NOP, 4'b1011, 1'b0);
        tick();
        reset = 1'b1;
        drive(32'h0, 4'h0, 1'b0);
        tick();
        reset = 1'b0;
        drive(NOP, 4'h0, 1'b0);
        tick();
        tick();

        // LDR pc: PC write pending through D, E, M1..M3
        expAt(0, SIG_PCPEND, 4'h0, "ldr_pcpend_before");
        tick();
        drive(LDRPC, 4'h0, 1'b0);
        expAt(0, SIG_IMMSRC, 4'h1, "ldr_immsrc");
        for (int i = 0; i <= MS + 1; i++) expAt(i, SIG_PCPEND, 4'h1, $sformatf("ldr_pcpend%0d", i));
        expAt(1,      SIG_MTRE,   4'h1, "ldr_mtre");
        expAt(1,      SIG_ALUCTL, 4'h4, "ldr_aluctl");
        expAt(MS + 1, SIG_PCSRCW, 4'h0, "ldr_pcsrcw_early");
        expAt(MS + 2, SIG_PCSRCW, 4'h1, "ldr_pcsrcw");
        expAt(MS + 2, SIG_MTRW,   4'h1, "ldr_mtrw");
        expAt(MS + 2, SIG_REGWW,  4'h1, "ldr_regww");
        expAt(MS + 2, SIG_PCPEND, 4'h0, "ldr_pcpend_done");
        tick();
        drive(NOP, 4'h0, 1'b0);
        for (int i = 0; i < 10; i++) tick();

        foreach (q[i]) begin
            nChecks++;
            nErrors++;
            $display("FAIL %s: expectation for cycle %0d never compared", q[i].tag, q[i].cyc);
        end
        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
